// File: rtl/rot_pkg.sv
// Shared types and constants for the two-requester rotate-left scheduler.
package rot_pkg;

    localparam int ROT_W   = 8;
    localparam int ROT_CW  = 3;
    localparam int ROT_IDW = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } rot_state_t;

endpackage

// File: rtl/rotl_core.sv
// W-bit rotate-left register: synchronous load, one-bit rotate per enabled cycle.
module rotl_core
    import rot_pkg::*;
#(
    parameter int W = ROT_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    input  logic         shift_en,
    output logic [W-1:0] rot_q
);

    // Rotator register; load has priority over shift.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rot_q <= '0;
        end else if (load_en) begin
            rot_q <= load_val;
        end else if (shift_en) begin
            rot_q <= {rot_q[W-2:0], rot_q[W-1]};
        end else begin
            rot_q <= rot_q;
        end
    end

endmodule

// File: rtl/rot_sched.sv
// Round-robin scheduler that feeds the shared rotator and returns tagged results.
module rot_sched
    import rot_pkg::*;
#(
    parameter int W  = ROT_W,
    parameter int CW = ROT_CW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_data,
    input  logic [CW-1:0] req0_amt,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_data,
    input  logic [CW-1:0] req1_amt,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_data,
    output logic          rsp_id,
    output logic          busy
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    rot_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ROT_IDW-1:0]   id_q, id_d;
    logic                 prio_q, prio_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 grant_s;
    logic [CW-1:0]        amt_s;
    logic                 load_en_s, shift_en_s;
    logic [W-1:0]         load_val_s;
    logic                 req0_ready_s, req1_ready_s;
    logic [W-1:0]         rot_q;

    rotl_core #(.W(W)) u_rotl_core (
        .clk      (clk),
        .rstn     (rstn),
        .load_en  (load_en_s),
        .load_val (load_val_s),
        .shift_en (shift_en_s),
        .rot_q    (rot_q)
    );

    // Arbiter, next-state logic and rotator control.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        prio_d       = prio_q;
        rsp_valid_d  = rsp_valid_q;
        load_en_s    = 1'b0;
        shift_en_s   = 1'b0;
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;

        if (req0_valid && req1_valid) begin
            grant_s = prio_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        load_val_s = grant_s ? req1_data : req0_data;
        amt_s      = grant_s ? req1_amt  : req0_amt;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready_s = ~grant_s;
                    req1_ready_s = grant_s;
                    load_en_s    = 1'b1;
                    cnt_d        = amt_s;
                    id_d         = grant_s;
                    prio_d       = ~grant_s;
                    if (amt_s == '0) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = ROT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ROT: begin
                shift_en_s = 1'b1;
                cnt_d      = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = ROT;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Scheduler state, counter, owner id, priority and response-valid flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            id_q        <= '0;
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            prio_q      <= prio_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Readies are gated by reset so an asserted rstn blocks acceptance at once.
    assign req0_ready = rstn & req0_ready_s;
    assign req1_ready = rstn & req1_ready_s;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rot_q;
    assign rsp_id     = id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rot_sched.sv
// Directed, scoreboard-based bench for rot_sched.
module tb_rot_sched;
    import rot_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic [2:0] req0_amt, req1_amt;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_data;

    typedef struct {
        logic [7:0] data;
        logic       id;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic prio_m = 1'b0;

    always #5 clk = ~clk;

    rot_sched #(.W(8), .CW(3)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl_m(input logic [7:0] d, input int a);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < a; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Call at a negedge with the request inputs already driven.
    task automatic accept_one(output int port, output int tries);
        logic exp_g;
        exp_t e;
        port  = -1;
        tries = 0;
        exp_g = (req0_valid && req1_valid) ? prio_m : (req1_valid ? 1'b1 : 1'b0);
        while (port < 0 && tries < 50) begin
            #1;
            if (req0_ready || req1_ready) begin
                port = req1_ready ? 1 : 0;
            end else begin
                tries++;
                @(negedge clk);
            end
        end
        if (port < 0) begin
            vectors++;
            miscompares++;
            $error("FAIL accept_timeout observed=no_ready expected=ready");
            return;
        end
        check("grant", 32'(port), 32'(exp_g));
        check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
        e.data = exp_g ? rotl_m(req1_data, int'(req1_amt)) : rotl_m(req0_data, int'(req0_amt));
        e.id   = exp_g;
        e.lat  = (exp_g ? int'(req1_amt) : int'(req0_amt)) + 1;
        sb.push_back(e);
        prio_m = ~exp_g;
        @(posedge clk);
        @(negedge clk);
        if (port == 1) req1_valid = 1'b0;
        else           req0_valid = 1'b0;
    endtask

    // Call at the negedge after the accepting edge.
    task automatic wait_rsp(input logic chk_busy);
        int   k;
        exp_t e;
        k = 1;
        while (!rsp_valid && k < 60) begin
            if (chk_busy) check("busy_rot", 32'(busy), 32'd1);
            @(negedge clk);
            k++;
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            check("latency", 32'(k), 32'(e.lat));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            if (chk_busy) check("busy_done", 32'(busy), 32'd1);
        end
    endtask

    task automatic drive(input int port, input logic [7:0] d, input logic [2:0] a);
        if (port == 1) begin
            req1_valid = 1'b1; req1_data = d; req1_amt = a;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_amt = a;
        end
    endtask

    task automatic job(input int port, input logic [7:0] d, input logic [2:0] a, input logic chk_busy);
        int p, t;
        @(negedge clk);
        drive(port, d, a);
        accept_one(p, t);
        wait_rsp(chk_busy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, t;
        rstn = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h00; req0_amt = 3'd0;
        req1_valid = 1'b1; req1_data = 8'h00; req1_amt = 3'd0;
        repeat (2) @(negedge clk);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        job(0, 8'h81, 3'd1, 1'b1);
        job(1, 8'hA5, 3'd0, 1'b1);
        job(0, 8'h01, 3'd7, 1'b1);
        job(1, 8'h3C, 3'd3, 1'b0);

        // First simultaneous pair: priority points at req0.
        @(negedge clk);
        drive(0, 8'h0F, 3'd4);
        drive(1, 8'h12, 3'd2);
        accept_one(p, t);
        wait_rsp(1'b0);
        @(negedge clk);
        accept_one(p, t);
        check("b2b_pair1", 32'(t), 32'd0);
        wait_rsp(1'b0);

        job(0, 8'h55, 3'd1, 1'b0);

        // Second simultaneous pair: priority now points at req1.
        @(negedge clk);
        drive(0, 8'hC3, 3'd3);
        drive(1, 8'h96, 3'd5);
        accept_one(p, t);
        check("pair2_first", 32'(p), 32'd1);
        wait_rsp(1'b0);
        @(negedge clk);
        accept_one(p, t);
        check("b2b_pair2", 32'(t), 32'd0);
        wait_rsp(1'b0);

        // Backpressure in DONE with a competing request pending.
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(0, 8'h33, 3'd2);
        accept_one(p, t);
        wait_rsp(1'b0);
        drive(1, 8'h0C, 3'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_data), 32'(rotl_m(8'h33, 2)));
            check("bp_id", 32'(rsp_id), 32'd0);
            check("bp_ready0", 32'(req0_ready), 32'd0);
            check("bp_ready1", 32'(req1_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        accept_one(p, t);
        check("bp_next_accept", 32'(t), 32'd0);
        wait_rsp(1'b0);

        // Reset two cycles into a rotation aborts the job.
        @(negedge clk);
        drive(0, 8'hFF, 3'd6);
        accept_one(p, t);
        @(negedge clk);
        drive(1, 8'h5A, 3'd3);
        rstn = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rsp_data", 32'(rsp_data), 32'd0);
        check("abort_rsp_id", 32'(rsp_id), 32'd0);
        check("abort_req1_ready", 32'(req1_ready), 32'd0);
        void'(sb.pop_back());
        prio_m = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        job(1, 8'h5A, 3'd3, 1'b1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
